hazard_ctrl_a: RTL
==================

// Module: hazard_ctrl_a
// PURPOSE
//  Lane-A hazard/forward controller; drives ForwardA1_E/ForwardA2_E selects of lane-A EX forward muxes.
//  Keeps its own pipelined destination tags (E->M->W) captured at the ID/EX boundary.
//  Detects load-use hazards (stall F/D, bubble E) and branch-taken redirects (flush D/E).
//  Lane B uses a separate instance; cross-lane hazards are handled by the issue logic, outside this block.
// PARAMETERS
//  REG_AW      5   register index width
//  CNT_W       32  perf counter width (HAZ_PERF_CNT_EN only)
// PORTS
//  clk           in   1       rising-edge clock
//  reset_n       in   1       asynchronous, active-low reset
//  Rs1A_D        in   REG_AW  source 1 of lane-A instr in ID
//  Rs2A_D        in   REG_AW  source 2 of lane-A instr in ID
//  RdA_D         in   REG_AW  destination of lane-A instr in ID
//  RegWriteA_D   in   1       ID instr writes the register file
//  LoadA_D       in   1       ID instr is a load (result available only at W)
//  PCSrcA_E      in   1       branch/jump taken, resolved in EX
//  ForwardA1_E   out  2       00 RD1A_E, 01 ResultA_W, 10 ALUResultA_M; 11 never driven
//  ForwardA2_E   out  2       same encoding, for source 2
//  StallA_F      out  1       hold PC
//  StallA_D      out  1       hold IF/ID register
//  FlushA_D      out  1       clear IF/ID register
//  FlushA_E      out  1       clear ID/EX register (bubble)
//  StallCnt      out  CNT_W   load-use stall cycles (HAZ_PERF_CNT_EN only)
//  FlushCnt      out  CNT_W   branch flush events   (HAZ_PERF_CNT_EN only)
// BEHAVIOUR
//  - Tag regs per stage S in {E,M,W}: rs1_S/rs2_S (E only), rd_S, we_S, ld_S. Each edge: D->E, E->M, M->W.
//  - FlushA_E=1: E tags load zero/we=0 (bubble); M<-E, W<-M still advance. StallA_D holds no tag regs.
//  - Reset (async, any cycle): all tags 0, we/ld 0. Outputs then: Forward*=00, Stall*/Flush*=0, counters 0.
//  - Forwarding, combinational from registered tags (0-cycle latency):
//    ForwardA1_E=10 if we_M && rd_M!=0 && rd_M==rs1_E; else 01 if we_W && rd_W!=0 && rd_W==rs1_E; else 00.
//    M beats W on a double match. Same rule for ForwardA2_E with rs2_E. x0 never forwards.
//  - Load-use: lu = ld_E && we_E && rd_E!=0 && (rd_E==Rs1A_D || rd_E==Rs2A_D).
//    lu -> StallA_F=StallA_D=1, FlushA_E=1 for exactly one cycle; the next cycle the load is in M,
//    stall clears, the dependent instr enters E and later gets 01 (from W).
//  - Branch: PCSrcA_E=1 -> FlushA_D=1, FlushA_E=1.
//  - Simultaneous lu and PCSrcA_E: flush wins; StallA_F=StallA_D=0 (dependent instr is squashed).
//  - Back-to-back loads with chained use: each lu event stalls one cycle; no accumulation.
//  - Flush of a load in E (PCSrcA_E from an older branch cannot coexist; load in E is not flushed by
//    its own PCSrcA_E) - ld_E only clears through FlushA_E applied at the next edge.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: StallCnt += 1 each cycle with StallA_D=1; FlushCnt += 1 each cycle with
//    PCSrcA_E=1; wrap modulo 2^CNT_W; cleared by reset only.
//  Undefined: StallCnt/FlushCnt ports tied to 0, no counter flops.
// STRUCTURE
//  Shared package riscv_pipe_pkg: typedef fwd_sel_t (enum 2'b00 FWD_RF, 2'b01 FWD_W, 2'b10 FWD_M),
//    typedef hz_tag_t struct {rd, we, ld}, localparam REG_X0 = '0.
//  One sub-module: hazard_tag_pipe (E/M/W tag registers with flush/bubble); compare logic stays in top.
// TESTING
//  1 add x5 in M, rs1_E=5 -> ForwardA1_E=10; same with rd_W=5 instead -> 01.
//  2 rd_M=rd_W=7, rs2_E=7 -> ForwardA2_E=10 (M priority); rd_M=0, we_M=1, rs1_E=0 -> 00.
//  3 lw x3 in E, Rs1A_D=3 -> one cycle StallA_F=StallA_D=FlushA_E=1, next cycle 0 and later ForwardA1_E=01.
//  4 PCSrcA_E=1 same cycle as load-use -> FlushA_D=FlushA_E=1, StallA_F=StallA_D=0.
//  5 reset_n low mid-stall -> all outputs 0/00 immediately, tags cleared; no forward after release.
//  6 HAZ_PERF_CNT_EN: 3 load-use events + 2 branches -> StallCnt=3, FlushCnt=2; undefined -> both 0.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types for the hazard/forward controllers.
//   fwd_sel_t : EX forward-mux select (RF / W-stage result / M-stage ALU result)
//   hz_tag_t  : per-stage destination tag {rd, we, ld}
//   REG_X0    : hard-wired zero register index, never forwarded or hazarded on
package riscv_pipe_pkg;

    localparam int HZ_REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic [HZ_REG_AW-1:0] rd;
        logic                 we;
        logic                 ld;
    } hz_tag_t;

    localparam logic [HZ_REG_AW-1:0] REG_X0 = '0;

    // M has priority over W: it holds the younger write to the same register.
    function automatic fwd_sel_t fwd_pick(input logic [HZ_REG_AW-1:0] src,
                                          input hz_tag_t m, input hz_tag_t w);
        if (m.we && m.rd != REG_X0 && m.rd == src)      return FWD_M;
        else if (w.we && w.rd != REG_X0 && w.rd == src) return FWD_W;
        else                                            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_tag_pipe.sv
// E/M/W destination-tag pipeline for one issue lane.
//   clk, reset_n      : clock, async active-low reset
//   i flush_e         : load a bubble into E instead of the ID instruction
//   i rs1_d/rs2_d     : ID source indices, kept only in E
//   i tag_d           : ID destination tag
//   o rs1_e/rs2_e     : E source indices
//   o tag_e/m/w       : per-stage destination tags
// M and W always advance; a stall of ID holds nothing here because the
// stalled cycle always coincides with a bubble in E.
module hazard_tag_pipe
    import riscv_pipe_pkg::*;
#(
    parameter int REG_AW = HZ_REG_AW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush_e,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  hz_tag_t           tag_d,
    output logic [REG_AW-1:0] rs1_e,
    output logic [REG_AW-1:0] rs2_e,
    output hz_tag_t           tag_e,
    output hz_tag_t           tag_m,
    output hz_tag_t           tag_w
);

    logic [REG_AW-1:0] r_rs1_e, r_rs2_e;
    hz_tag_t           r_tag_e, r_tag_m, r_tag_w;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rs1_e <= '0;
            r_rs2_e <= '0;
            r_tag_e <= '0;
            r_tag_m <= '0;
            r_tag_w <= '0;
        end else begin
            if (flush_e) begin
                r_rs1_e <= '0;
                r_rs2_e <= '0;
                r_tag_e <= '0;
            end else begin
                r_rs1_e <= rs1_d;
                r_rs2_e <= rs2_d;
                r_tag_e <= tag_d;
            end
            r_tag_m <= r_tag_e;
            r_tag_w <= r_tag_m;
        end
    end

    assign rs1_e = r_rs1_e;
    assign rs2_e = r_rs2_e;
    assign tag_e = r_tag_e;
    assign tag_m = r_tag_m;
    assign tag_w = r_tag_w;

endmodule

// File: rtl/hazard_ctrl_a.sv
// Lane-A hazard / forwarding controller.
//   clk, reset_n                 : clock, async active-low reset
//   Rs1A_D, Rs2A_D, RdA_D        : lane-A ID register indices
//   RegWriteA_D, LoadA_D         : ID instr writes RF / is a load
//   PCSrcA_E                     : taken branch/jump resolved in EX
//   ForwardA1_E, ForwardA2_E     : EX forward selects (00 RF, 01 W, 10 M)
//   StallA_F, StallA_D           : hold PC / IF-ID on load-use
//   FlushA_D, FlushA_E           : clear IF-ID / bubble ID-EX
//   StallCnt, FlushCnt           : perf counters
// Build option: define HAZ_PERF_CNT_EN to implement the perf counters;
// otherwise they read constant zero.
module hazard_ctrl_a
    import riscv_pipe_pkg::*;
#(
    parameter int REG_AW = HZ_REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] Rs1A_D,
    input  logic [REG_AW-1:0] Rs2A_D,
    input  logic [REG_AW-1:0] RdA_D,
    input  logic              RegWriteA_D,
    input  logic              LoadA_D,
    input  logic              PCSrcA_E,
    output logic [1:0]        ForwardA1_E,
    output logic [1:0]        ForwardA2_E,
    output logic              StallA_F,
    output logic              StallA_D,
    output logic              FlushA_D,
    output logic              FlushA_E,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    logic [REG_AW-1:0] w_rs1_e, w_rs2_e;
    hz_tag_t           w_tag_d, w_tag_e, w_tag_m, w_tag_w;
    logic              w_lu;
    fwd_sel_t          w_fwd1, w_fwd2;

    assign w_tag_d = '{rd: RdA_D, we: RegWriteA_D, ld: LoadA_D};

    hazard_tag_pipe #(.REG_AW(REG_AW)) u_tags (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_e (FlushA_E),
        .rs1_d   (Rs1A_D),
        .rs2_d   (Rs2A_D),
        .tag_d   (w_tag_d),
        .rs1_e   (w_rs1_e),
        .rs2_e   (w_rs2_e),
        .tag_e   (w_tag_e),
        .tag_m   (w_tag_m),
        .tag_w   (w_tag_w)
    );

    assign w_fwd1      = fwd_pick(w_rs1_e, w_tag_m, w_tag_w);
    assign w_fwd2      = fwd_pick(w_rs2_e, w_tag_m, w_tag_w);
    assign ForwardA1_E = w_fwd1;
    assign ForwardA2_E = w_fwd2;

    // Load result only exists at W, so a consumer directly behind it must wait one cycle.
    assign w_lu = w_tag_e.ld && w_tag_e.we && (w_tag_e.rd != REG_X0) &&
                  ((w_tag_e.rd == Rs1A_D) || (w_tag_e.rd == Rs2A_D));

    // A taken branch squashes the dependent instr, so stalling for it would be pointless.
    assign StallA_F = w_lu && !PCSrcA_E;
    assign StallA_D = w_lu && !PCSrcA_E;
    assign FlushA_D = PCSrcA_E;
    assign FlushA_E = w_lu || PCSrcA_E;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (StallA_D) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (PCSrcA_E) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule
